// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register map, status bit positions, AXI responses and TX FSM states
package uart_ctrl_pkg;
  localparam logic [2:0] OFF_TXDATA   = 3'd0;
  localparam logic [2:0] OFF_RXDATA   = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_PRESCALE = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_RX_BUSY  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_TX_OVF   = 5;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_e;
  function automatic logic off_valid(input logic [2:0] off);
    return off <= OFF_CTRL;
  endfunction
endpackage

// File: rtl/uart_axil_regif.sv
// uart_axil_regif: AXI-Lite handshake and decode into one-cycle register strobes
module uart_axil_regif
  import uart_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  wr_en_o,
  output logic [2:0]            wr_off_o,
  output logic [31:0]           wr_data_o,
  output logic [3:0]            wr_strb_o,
  input  logic                  wr_err_i,
  output logic                  rd_en_o,
  output logic [2:0]            rd_off_o,
  input  logic [31:0]           rd_data_i
);
  logic        wr_hs, rd_hs, wr_ok, rd_ok;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        unused_addr;
  // AW and W are only taken together, and only while no response is outstanding
  assign wr_hs     = s_awvalid & s_wvalid & ~bvalid_q;
  assign rd_hs     = s_arvalid & ~rvalid_q;
  assign s_awready = wr_hs;
  assign s_wready  = wr_hs;
  assign s_arready = rd_hs;
  assign wr_off_o  = s_awaddr[4:2];
  assign rd_off_o  = s_araddr[4:2];
  assign wr_ok     = off_valid(wr_off_o);
  assign rd_ok     = off_valid(rd_off_o);
  assign wr_en_o   = wr_hs & wr_ok;
  assign rd_en_o   = rd_hs & rd_ok;
  assign wr_data_o = s_wdata;
  assign wr_strb_o = s_wstrb;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign unused_addr = ^{s_awaddr, s_araddr};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_ok & ~wr_err_i) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= rd_ok ? rd_data_i : '0;
      end else if (s_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/uart_axil_ctrl.sv
// uart_axil_ctrl: AXI-Lite control block sequencing one uart_top through TX/RX holding registers
module uart_axil_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] uart_tx_data,
  output logic                  uart_tx_start,
  input  logic                  uart_tx_busy,
  input  logic [DATA_WIDTH-1:0] uart_rx_data,
  input  logic                  uart_rx_ready,
  input  logic                  uart_rx_busy,
  output logic [15:0]           uart_prescale,
  output logic                  irq
);
  logic                  wr_en, rd_en, wr_err;
  logic [2:0]            wr_off, rd_off;
  logic [31:0]           wr_data, rd_data, status;
  logic [3:0]            wr_strb;
  logic                  tx_wr, st_wr, pre_wr, ctrl_wr, rx_pop, launch, tx_load, tx_busy;
  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d, tx_data_q, tx_data_d, rx_hold_q, rx_hold_d;
  logic                  tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
  logic                  rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d, irq_q, irq_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic                  unused_wr;

  uart_axil_regif #(.ADDR_WIDTH(ADDR_WIDTH)) u_regif (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_en_o(wr_en), .wr_off_o(wr_off), .wr_data_o(wr_data), .wr_strb_o(wr_strb),
    .wr_err_i(wr_err), .rd_en_o(rd_en), .rd_off_o(rd_off), .rd_data_i(rd_data)
  );

  assign tx_wr   = wr_en & (wr_off == OFF_TXDATA) & wr_strb[0];
  assign st_wr   = wr_en & (wr_off == OFF_STATUS) & wr_strb[0];
  assign pre_wr  = wr_en & (wr_off == OFF_PRESCALE);
  assign ctrl_wr = wr_en & (wr_off == OFF_CTRL) & wr_strb[0];
  assign rx_pop  = rd_en & (rd_off == OFF_RXDATA);
  assign launch  = (state_q == TX_IDLE) & tx_full_q & ~uart_tx_busy;
  // the holding slot frees on the launch edge, so a write landing then is still accepted
  assign tx_load = tx_wr & (~tx_full_q | launch);
  assign wr_err  = tx_wr & ~tx_load;
  assign tx_busy = uart_tx_busy | (state_q != TX_IDLE);
  assign status  = {26'd0, tx_ovf_q, rx_ovr_q, uart_rx_busy, tx_busy, tx_full_q, rx_valid_q};
  assign rd_data = (rd_off == OFF_RXDATA)   ? {{(32-DATA_WIDTH){1'b0}}, rx_valid_q ? rx_hold_q : '0} :
                   (rd_off == OFF_STATUS)   ? status :
                   (rd_off == OFF_PRESCALE) ? {16'd0, prescale_q} :
                   (rd_off == OFF_CTRL)     ? {30'd0, ctrl_q} : '0;
  assign unused_wr = ^{wr_data, wr_strb};

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:      state_d = launch ? TX_START : TX_IDLE;
      TX_START:     state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: state_d = uart_tx_busy ? TX_WAIT_DONE : TX_WAIT_BUSY;
      TX_WAIT_DONE: state_d = uart_tx_busy ? TX_WAIT_DONE : TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_full_d  = tx_load | (tx_full_q & ~launch);
    tx_hold_d  = tx_load ? wr_data[DATA_WIDTH-1:0] : tx_hold_q;
    tx_data_d  = launch ? tx_hold_q : tx_data_q;
    tx_ovf_d   = wr_err | (tx_ovf_q & ~(st_wr & wr_data[ST_TX_OVF]));
    rx_valid_d = uart_rx_ready | (rx_valid_q & ~rx_pop);
    rx_hold_d  = uart_rx_ready ? uart_rx_data : rx_hold_q;
    rx_ovr_d   = (uart_rx_ready & rx_valid_q & ~rx_pop) | (rx_ovr_q & ~(st_wr & wr_data[ST_RX_OVR]));
    prescale_d = {(pre_wr & wr_strb[1]) ? wr_data[15:8] : prescale_q[15:8],
                  (pre_wr & wr_strb[0]) ? wr_data[7:0]  : prescale_q[7:0]};
    ctrl_d     = ctrl_wr ? wr_data[1:0] : ctrl_q;
    irq_d      = (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & ~tx_full_q & (state_q == TX_IDLE)) |
                 rx_ovr_q | tx_ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      tx_hold_q  <= '0;
      tx_data_q  <= '0;
      tx_full_q  <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_hold_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      prescale_q <= '0;
      ctrl_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_hold_q  <= tx_hold_d;
      tx_data_q  <= tx_data_d;
      tx_full_q  <= tx_full_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_hold_q  <= rx_hold_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      prescale_q <= prescale_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  assign uart_tx_data  = tx_data_q;
  assign uart_tx_start = (state_q == TX_START);
  assign uart_prescale = prescale_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_uart_axil_ctrl.sv
// tb_uart_axil_ctrl: directed checks of the AXI-Lite UART controller against hand-computed values
module tb_uart_axil_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_start, uart_rx_ready, uart_rx_busy, irq;
  logic        uart_tx_busy = 1'b0;
  logic [15:0] uart_prescale;
  int          total = 0;
  int          bad = 0;
  int          start_cnt = 0;
  int          bcnt = 0;
  logic [7:0]  last_tx = '0;

  always #5 clk = ~clk;

  uart_axil_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready), .uart_rx_busy(uart_rx_busy),
    .uart_prescale(uart_prescale), .irq(irq)
  );

  // transmitter model: busy rises the cycle after a start pulse and lasts 20 cycles
  always @(posedge clk) begin
    if (uart_tx_start) begin
      start_cnt    <= start_cnt + 1;
      last_tx      <= uart_tx_data;
      uart_tx_busy <= 1'b1;
      bcnt         <= 20;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) uart_tx_busy <= 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    n = 0;
    while (!s_awready && n < 20) begin @(negedge clk); #1; n++; end
    if (n == 20) begin total++; bad++; $display("FAIL aw_accept: timeout addr %h", a); end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin total++; bad++; $display("FAIL bvalid: timeout addr %h", a); end
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, input logic inj, input logic [7:0] b,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1;
    if (inj) begin uart_rx_data = b; uart_rx_ready = 1'b1; end
    #1;
    n = 0;
    while (!s_arready && n < 20) begin @(negedge clk); #1; n++; end
    if (n == 20) begin total++; bad++; $display("FAIL ar_accept: timeout addr %h", a); end
    @(posedge clk); #1;
    s_arvalid = 1'b0; uart_rx_ready = 1'b0;
    n = 0;
    while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin total++; bad++; $display("FAIL rvalid: timeout addr %h", a); end
    data = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    uart_rx_data = b; uart_rx_ready = 1'b1;
    @(negedge clk);
    uart_rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    total++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, uart_tx_start, irq} !== 7'd0) begin
      bad++; $display("FAIL reset_ctl: got %b want 0", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, uart_tx_start, irq});
    end
    total++;
    if ({s_bresp, s_rresp, s_rdata, uart_tx_data, uart_prescale} !== 60'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {s_bresp, s_rresp, s_rdata, uart_tx_data, uart_prescale});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      axi_read(5'(i * 4), 1'b0, 8'h00, d, r);
      total++;
      if (d !== 32'h0 || r !== 2'b00) begin
        bad++; $display("FAIL reset_read_%0h: got %h/%b want 00000000/00", i * 4, d, r);
      end
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h0C, 32'h0000_01B2, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL pre_bresp: got %b want 00", r); end
    total++;
    if (uart_prescale !== 16'd434) begin bad++; $display("FAIL pre_out: got %0d want 434", uart_prescale); end
    axi_read(5'h0C, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h0000_01B2) begin bad++; $display("FAIL pre_read: got %h want 000001b2", d); end
    axi_write(5'h0C, 32'h0000_ABCD, 4'b0001, r);
    axi_read(5'h0C, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h0000_01CD) begin bad++; $display("FAIL pre_strb: got %h want 000001cd", d); end
  endtask

  task automatic test_tx();
    logic [31:0] d;
    logic [1:0]  r;
    int          n;
    axi_write(5'h00, 32'h55, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL tx1_bresp: got %b want 00", r); end
    repeat (2) @(negedge clk);
    total++;
    if (start_cnt !== 1 || last_tx !== 8'h55) begin
      bad++; $display("FAIL tx1_start: got cnt=%0d data=%h want cnt=1 data=55", start_cnt, last_tx);
    end
    axi_write(5'h00, 32'hA3, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL tx2_bresp: got %b want 00", r); end
    axi_write(5'h00, 32'hCC, 4'hF, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL tx3_bresp: got %b want 10", r); end
    axi_read(5'h08, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h26) begin bad++; $display("FAIL tx_status: got %h want 00000026", d); end
    total++;
    if (uart_tx_data !== 8'h55 || start_cnt !== 1) begin
      bad++; $display("FAIL tx_hold_stable: got data=%h cnt=%0d want 55/1", uart_tx_data, start_cnt);
    end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL tx_ovf_irq: got %b want 1", irq); end
    n = 0;
    while (start_cnt < 2 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (start_cnt !== 2 || last_tx !== 8'hA3) begin
      bad++; $display("FAIL tx2_start: got cnt=%0d data=%h want cnt=2 data=a3", start_cnt, last_tx);
    end
    n = 0;
    while (bcnt != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    axi_write(5'h08, 32'h20, 4'hF, r);
    axi_read(5'h08, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h0 || start_cnt !== 2) begin
      bad++; $display("FAIL tx_idle_status: got %h cnt=%0d want 00000000 cnt=2", d, start_cnt);
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL tx_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h10, 32'h1, 4'hF, r);
    rx_pulse(8'h3C);
    repeat (2) @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL rx_irq: got %b want 1", irq); end
    axi_read(5'h04, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h3C || r !== 2'b00) begin bad++; $display("FAIL rx_data: got %h/%b want 0000003c/00", d, r); end
    axi_read(5'h08, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rx_status: got %h want 00000000", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL rx_irq_clear: got %b want 0", irq); end
    axi_read(5'h04, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL rx_empty: got %h/%b want 00000000/00", d, r); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [1:0]  r;
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    axi_read(5'h08, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h11) begin bad++; $display("FAIL ovr_status: got %h want 00000011", d); end
    axi_read(5'h04, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h22) begin bad++; $display("FAIL ovr_data: got %h want 00000022", d); end
    axi_write(5'h08, 32'h10, 4'hF, r);
    axi_read(5'h08, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ovr_w1c: got %h want 00000000", d); end
    rx_pulse(8'h33);
    axi_read(5'h04, 1'b1, 8'h44, d, r);
    total++;
    if (d !== 32'h33) begin bad++; $display("FAIL pop_coincide_data: got %h want 00000033", d); end
    axi_read(5'h08, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h01) begin bad++; $display("FAIL pop_coincide_status: got %h want 00000001", d); end
    axi_read(5'h04, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h44) begin bad++; $display("FAIL pop_coincide_next: got %h want 00000044", d); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL bad_wr: got %b want 10", r); end
    axi_read(5'h14, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL bad_rd: got %h/%b want 00000000/10", d, r); end
    axi_read(5'h10, 1'b0, 8'h00, d, r);
    total++;
    if (d !== 32'h1 || uart_prescale !== 16'h01CD) begin
      bad++; $display("FAIL bad_side_effect: got ctrl=%h pre=%h want 00000001/01cd", d, uart_prescale);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    s_awaddr = 5'h0C; s_wdata = 32'h1234; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_wdata = 32'h9999;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000 || uart_prescale !== 16'h1234) begin
        bad++; $display("FAIL b_stall_%0d: got v/resp/rdy=%b pre=%h want 10000/1234", i, {s_bvalid, s_bresp, s_awready, s_wready}, uart_prescale);
      end
    end
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    total++;
    if (s_bvalid !== 1'b0 || uart_prescale !== 16'h1234) begin
      bad++; $display("FAIL b_release: got v=%b pre=%h want 0/1234", s_bvalid, uart_prescale);
    end
    s_araddr = 5'h0C; s_arvalid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (s_rvalid !== 1'b1 || s_arready !== 1'b0 || s_rdata !== 32'h1234 || s_rresp !== 2'b00) begin
        bad++; $display("FAIL r_stall_%0d: got v=%b rdy=%b data=%h resp=%b want 1/0/00001234/00", i, s_rvalid, s_arready, s_rdata, s_rresp);
      end
    end
    @(negedge clk);
    s_arvalid = 1'b0; s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    @(negedge clk);
    total++;
    if (s_rvalid !== 1'b0) begin bad++; $display("FAIL r_release: got %b want 0", s_rvalid); end
  endtask

  initial begin
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
    uart_rx_data = '0; uart_rx_ready = 1'b0; uart_rx_busy = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_prescale();
    test_tx();
    test_rx();
    test_overrun();
    test_bad_addr();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_axil_ctrl.md
Name: uart_axil_ctrl

Overview:
AXI4-Lite slave that configures and sequences one uart_top instance for a host CPU. Holds a one-entry TX holding register and a one-entry RX holding register, and pulses tx_start when the transmitter is free. Provides status/sticky-error bits, a programmable prescale and a level interrupt. Sits between the SoC AXI-Lite interconnect and the uart_top TX/RX/config ports.

Parameters:
DATA_WIDTH, 8, UART character width; must match uart_top
ADDR_WIDTH, 5, AXI-Lite byte-address width; decoder uses addr[4:2]

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_WIDTH  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
uart_tx_data  out  DATA_WIDTH  to uart_top tx_data
uart_tx_start  out  1  one-cycle start pulse to uart_top
uart_tx_busy  in  1  from uart_top
uart_rx_data  in  DATA_WIDTH  from uart_top
uart_rx_ready  in  1  one-cycle byte-received strobe
uart_rx_busy  in  1  from uart_top
uart_prescale  out  16  to uart_top prescale (0 selects its default)
irq  out  1  level interrupt

Behaviour:
- Reset: all AXI ready/valid outputs 0, bresp/rresp/rdata 0, uart_tx_start 0, uart_tx_data 0, uart_prescale 0, irq 0, holding regs empty, sticky bits 0, CTRL 0, TX FSM IDLE.
- Register map (word offsets): 0x00 TXDATA W; 0x04 RXDATA R; 0x08 STATUS R/W1C; 0x0C PRESCALE RW [15:0]; 0x10 CTRL RW [1:0]. Other offsets: SLVERR, read data 0, no side effect.
- STATUS bits: 0 rx_valid, 1 tx_full, 2 tx_busy (uart_tx_busy or FSM not IDLE), 3 rx_busy, 4 rx_overrun (sticky, W1C), 5 tx_overflow (sticky, W1C). Unused bits read 0.
- Write channel: s_awready=s_wready=1 for exactly one cycle when awvalid&wvalid&!bvalid; register update same edge; bvalid next cycle, held until bready. No AW/W skid; neither accepted alone.
- Read channel: s_arready=1 one cycle when arvalid&!rvalid; rdata/rresp registered, rvalid next cycle, held stable until rready.
- wstrb: PRESCALE honours lanes 0/1 per byte; TXDATA, STATUS, CTRL require wstrb[0], else write ignored with OKAY.
- TXDATA write: holding empty -> load, tx_full=1. Holding full -> data dropped, tx_overflow=1, bresp SLVERR.
- TX FSM: IDLE -(tx_full & !uart_tx_busy)-> START: uart_tx_start=1 one cycle, uart_tx_data=holding, holding cleared -> WAIT_BUSY until uart_tx_busy=1 -> WAIT_DONE until uart_tx_busy=0 -> IDLE. uart_tx_data held stable from START until IDLE. A new TXDATA write may load the holding reg during WAIT_*.
- RX: uart_rx_ready loads holding, rx_valid=1. If rx_valid already 1 and no pop that cycle: overwrite with new byte, rx_overrun=1.
- RXDATA read accepted (arready edge): rdata={0,holding} and rx_valid cleared; if empty, rdata=0, OKAY. Pop and uart_rx_ready same cycle: new byte loaded, rx_valid stays 1, no overrun.
- Sticky set and W1C in same cycle: set wins.
- irq = (CTRL[0] & rx_valid) | (CTRL[1] & !tx_full & FSM IDLE) | rx_overrun | tx_overflow; registered, one-cycle latency.
- uart_prescale driven directly from PRESCALE register; write takes effect next cycle, mid-character changes are not guarded.
- Reset mid-operation: all state returns to reset values immediately; an in-flight character in uart_top is not tracked.

Decomposition:
- Package uart_ctrl_pkg: register offsets, STATUS bit indices, AXI response codes, TX FSM state enum.
- Sub-module uart_axil_regif: AXI-Lite handshake plus address decode, emitting one-cycle wr_en/rd_en strobes with offset/data; top holds holding regs, TX FSM, sticky logic, irq.

Test Plan:
- Reset, then read 0x08, 0x0C, 0x10 -> all 0x00000000 OKAY; irq=0.
- Write 0x0C=0x000001B2, read back -> 0x000001B2; uart_prescale=16'd434 next cycle.
- Write 0x00=0x55 with tx_busy model (busy rises 1 cycle after start, 20 cycles) -> single uart_tx_start pulse with uart_tx_data=0x55; second write 0x00=0xA3 during busy -> OKAY, sent after busy falls; third write while holding full -> SLVERR, STATUS=0x26 (tx_full, tx_busy, tx_overflow).
- uart_rx_ready with 0x3C, CTRL=1 -> irq=1; read 0x04 -> 0x3C, rx_valid=0, irq=0; read again -> 0x00.
- Two rx_ready (0x11, 0x22) without read -> STATUS bit4=1, read 0x04 -> 0x22; write 0x08=0x10 -> bit4 cleared; rx_ready coincident with RXDATA read -> no overrun.
- Access 0x14 read and write -> SLVERR, rdata 0; bready/rready held low 5 cycles -> bvalid/rvalid and data stable, no new accept.
